// File: rtl/fibo_stream_gen_if.sv
// Term stream carried from the Fibonacci-class generator to a consumer.
// The consumer side may apply backpressure through out_ready.
interface fibo_stream_gen_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
);
  // valid/ready: a term transfers on a clock edge where out_valid && out_ready.
  // While out_valid=1 and out_ready=0, out_data/out_idx/out_ovf/out_last hold,
  // and once raised out_valid stays high until that term transfers.
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_ovf;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_idx, out_ovf, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_ovf, out_last,
    output out_ready
  );
endinterface

// File: rtl/fibo_stream_gen.sv
// Two-term additive recurrence generator (Fibonacci, Lucas, custom seeds)
// streaming terms 0..last_n with a sticky wrap flag and a done pulse.
module fibo_stream_gen #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   seed_a,
  input  logic [WIDTH-1:0]   seed_b,
  input  logic [IDX_W-1:0]   last_n,
  fibo_stream_gen_if.master  stream,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             cur_ovf;
  logic             nxt_ovf;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] last_q;
  logic [WIDTH:0]   sum;
  logic             run;
  logic             fire;
  logic             is_last;

  assign run     = (state_q == ST_RUN);
  assign is_last = (k == last_q);
  assign fire    = run && stream.out_ready;
  assign sum     = {1'b0, cur} + {1'b0, nxt};

  // nxt_ovf is the wrap flag of the pending term; it only ever accumulates,
  // so it also carries any wrap inherited from earlier terms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cur     <= '0;
      nxt     <= '0;
      cur_ovf <= 1'b0;
      nxt_ovf <= 1'b0;
      k       <= '0;
      last_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur     <= seed_a;
            nxt     <= seed_b;
            cur_ovf <= 1'b0;
            nxt_ovf <= 1'b0;
            k       <= '0;
            last_q  <= last_n;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (fire) begin
            if (is_last) begin
              state_q <= ST_DONE;
            end else begin
              cur     <= nxt;
              cur_ovf <= nxt_ovf;
              nxt     <= sum[WIDTH-1:0];
              nxt_ovf <= nxt_ovf | sum[WIDTH];
              k       <= k + IDX_W'(1);
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated by RUN so that IDLE/DONE (and reset) present all zeros.
  assign stream.out_valid = run;
  assign stream.out_data  = run ? cur : '0;
  assign stream.out_idx   = run ? k : '0;
  assign stream.out_ovf   = run && cur_ovf;
  assign stream.out_last  = run && is_last;
  assign busy             = run;
  assign done             = (state_q == ST_DONE);
  assign state            = state_q;

endmodule

// File: tb/tb_fibo_stream_gen.sv
// Bench for fibo_stream_gen: directed and randomized sequences checked against
// an arithmetic reference model of the recurrence.
module tb_fibo_stream_gen;
  localparam int W  = 32;
  localparam int IW = 6;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  seed_a;
  logic [W-1:0]  seed_b;
  logic [IW-1:0] last_n;
  logic          busy;
  logic          done;
  logic [1:0]    state;

  fibo_stream_gen_if #(.WIDTH(W), .IDX_W(IW)) stream ();

  fibo_stream_gen #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .seed_a (seed_a),
    .seed_b (seed_b),
    .last_n (last_n),
    .stream (stream),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected terms and wrap flags from the reference model
  logic [W-1:0]  exp_q[$];
  logic          exp_ovf_q[$];

  // Observed transfers collected by the driver
  logic [W-1:0]  obs_data[$];
  logic [IW-1:0] obs_idx[$];
  logic          obs_ovf[$];
  logic          obs_last[$];
  int            obs_cyc[$];
  bit            done_seen;
  int            done_cyc;
  int            hold_bad;
  int            busy_bad;

  task automatic build_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int ln);
    longint unsigned p, q, s;
    bit ovf;
    exp_q.delete();
    exp_ovf_q.delete();
    p = a; q = b; ovf = 1'b0;
    for (int n = 0; n <= ln; n++) begin
      if (n == 0) begin
        exp_q.push_back(a); exp_ovf_q.push_back(1'b0);
      end else if (n == 1) begin
        exp_q.push_back(b); exp_ovf_q.push_back(1'b0);
      end else begin
        s = p + q;
        if (s >= MOD) begin
          ovf = 1'b1;
          s = s - MOD;
        end
        exp_q.push_back(W'(s)); exp_ovf_q.push_back(ovf);
        p = q; q = s;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where term 0 is visible.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input int ln);
    seed_a = a; seed_b = b; last_n = IW'(ln);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic collect(input int mode, input int budget);
    logic [W+IW+1:0] prev;
    bit prev_hold;
    logic r;
    obs_data.delete(); obs_idx.delete(); obs_ovf.delete(); obs_last.delete(); obs_cyc.delete();
    done_seen = 1'b0; done_cyc = -1; hold_bad = 0; busy_bad = 0;
    prev_hold = 1'b0; prev = '0;
    for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
      if (done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else begin
        if (busy !== stream.out_valid) busy_bad++;
        if (prev_hold && ({stream.out_data, stream.out_idx, stream.out_ovf, stream.out_last} !== prev))
          hold_bad++;
        case (mode)
          0:       r = 1'b1;
          1:       r = (cyc % 3 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        stream.out_ready = r;
        if (stream.out_valid === 1'b1 && r) begin
          obs_data.push_back(stream.out_data);
          obs_idx.push_back(stream.out_idx);
          obs_ovf.push_back(stream.out_ovf);
          obs_last.push_back(stream.out_last);
          obs_cyc.push_back(cyc);
        end
        prev_hold = (stream.out_valid === 1'b1) && !r;
        prev = {stream.out_data, stream.out_idx, stream.out_ovf, stream.out_last};
        @(negedge clk);
      end
    end
    stream.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    seed_a = '0; seed_b = '0; last_n = '0; stream.out_ready = 1'b0;
    #12;
    checks++;
    if ({stream.out_valid, stream.out_data, stream.out_idx, stream.out_ovf, stream.out_last, busy, done, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b data=%h idx=%0d ovf=%b last=%b busy=%b done=%b state=%0d exp all 0",
               stream.out_valid, stream.out_data, stream.out_idx, stream.out_ovf, stream.out_last, busy, done, state);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fibonacci();
    logic [W-1:0] fib [11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    do_start(0, 1, 10);
    collect(0, 40);
    checks++;
    if (obs_data.size() != 11) begin
      errors++; $display("FAIL fib_count got=%0d exp=11", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < 11; i++) begin
      checks++;
      if (obs_data[i] !== fib[i] || obs_idx[i] !== IW'(i) || obs_ovf[i] !== 1'b0 ||
          obs_last[i] !== (i == 10) || obs_cyc[i] != i) begin
        errors++;
        $display("FAIL fib_term%0d got data=%0d idx=%0d ovf=%b last=%b cyc=%0d exp data=%0d idx=%0d ovf=0 last=%b cyc=%0d",
                 i, obs_data[i], obs_idx[i], obs_ovf[i], obs_last[i], obs_cyc[i], fib[i], i, (i == 10), i);
      end
    end
    checks++;
    if (!done_seen || done_cyc != 11) begin
      errors++; $display("FAIL fib_done got seen=%0d cyc=%0d exp seen=1 cyc=11", done_seen, done_cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL fib_busy got bad_cycles=%0d exp=0", busy_bad);
    end
    @(negedge clk);
  endtask

  task automatic test_lucas_backpressure();
    logic [W-1:0] luc [6] = '{2, 1, 3, 4, 7, 11};
    do_start(2, 1, 5);
    collect(1, 60);
    checks++;
    if (obs_data.size() != 6) begin
      errors++; $display("FAIL lucas_count got=%0d exp=6", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < 6; i++) begin
      checks++;
      if (obs_data[i] !== luc[i] || obs_idx[i] !== IW'(i) || obs_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL lucas_term%0d got data=%0d idx=%0d last=%b exp data=%0d idx=%0d last=%b",
                 i, obs_data[i], obs_idx[i], obs_last[i], luc[i], i, (i == 5));
      end
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL lucas_hold got unstable_cycles=%0d exp=0", hold_bad);
    end
    checks++;
    if (!done_seen || obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1) begin
      errors++; $display("FAIL lucas_done got seen=%0d cyc=%0d exp one cycle after last transfer", done_seen, done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_start(0, 1, 49);
    build_exp(0, 1, 49);
    collect(2, 400);
    checks++;
    if (obs_data.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_count got=%0d exp=%0d", obs_data.size(), exp_q.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_q[i] || obs_ovf[i] !== exp_ovf_q[i] || obs_idx[i] !== IW'(i)) begin
        errors++;
        $display("FAIL ovf_term%0d got data=%h ovf=%b idx=%0d exp data=%h ovf=%b idx=%0d",
                 i, obs_data[i], obs_ovf[i], obs_idx[i], exp_q[i], exp_ovf_q[i], i);
      end
    end
    if (obs_data.size() == 50) begin
      checks++;
      if (obs_data[47] !== 32'hB11924E1 || obs_ovf[47] !== 1'b0 ||
          obs_data[48] !== 32'h1E8D0A40 || obs_ovf[48] !== 1'b1 || obs_ovf[49] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_boundary got t47=%h/%b t48=%h/%b ovf49=%b exp t47=b11924e1/0 t48=1e8d0a40/1 ovf49=1",
                 obs_data[47], obs_ovf[47], obs_data[48], obs_ovf[48], obs_ovf[49]);
      end
    end
    checks++;
    if (hold_bad != 0 || !done_seen) begin
      errors++; $display("FAIL ovf_handshake got unstable=%0d done_seen=%0d exp 0 and 1", hold_bad, done_seen);
    end
    @(negedge clk);
  endtask

  task automatic test_last_zero();
    do_start(32'hDEAD, 32'h1234, 0);
    collect(0, 10);
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'hDEAD || obs_last[0] !== 1'b1 || obs_idx[0] !== '0) begin
      errors++;
      $display("FAIL last0_term got count=%0d data=%h last=%b exp count=1 data=0000dead last=1",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : '0, (obs_data.size() > 0) ? obs_last[0] : 1'b0);
    end
    checks++;
    if (!done_seen || done_cyc != 1) begin
      errors++; $display("FAIL last0_done got seen=%0d cyc=%0d exp seen=1 cyc=1", done_seen, done_cyc);
    end
    // A start during the DONE cycle must not launch a sequence
    seed_a = 32'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (stream.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_in_done got valid=%b busy=%b done=%b exp 0 0 0", stream.out_valid, busy, done);
    end
    @(negedge clk);
    checks++;
    if (stream.out_valid !== 1'b0) begin
      errors++; $display("FAIL start_in_done_late got valid=%b exp=0", stream.out_valid);
    end
  endtask

  task automatic test_start_in_run();
    do_start(5, 8, 4);
    seed_a = 32'd100; seed_b = 32'd200; last_n = 6'd1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    build_exp(5, 8, 4);
    collect(0, 20);
    checks++;
    if (obs_data.size() != exp_q.size()) begin
      errors++; $display("FAIL run_start_count got=%0d exp=%0d", obs_data.size(), exp_q.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 4)) begin
        errors++;
        $display("FAIL run_start_term%0d got data=%0d last=%b exp data=%0d last=%b", i, obs_data[i], obs_last[i], exp_q[i], (i == 4));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int done_hits = 0;
    do_start(0, 1, 20);
    stream.out_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      if (stream.out_idx === 6'd4) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort_reach_idx4 got=%0d exp=4", stream.out_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    stream.out_ready = 1'b0;
    checks++;
    if (stream.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle got valid=%b busy=%b done=%b exp 0 0 0", stream.out_valid, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_hits++;
    end
    checks++;
    if (done_hits != 0) begin
      errors++; $display("FAIL abort_no_done got pulses=%0d exp=0", done_hits);
    end
    do_start(7, 9, 3);
    checks++;
    if (stream.out_idx !== '0 || stream.out_data !== 32'd7 || stream.out_valid !== 1'b1) begin
      errors++; $display("FAIL abort_restart got idx=%0d data=%0d valid=%b exp idx=0 data=7 valid=1",
                         stream.out_idx, stream.out_data, stream.out_valid);
    end
    build_exp(7, 9, 3);
    collect(0, 20);
    checks++;
    if (obs_data.size() != 4 || obs_data[3] !== exp_q[3] || !done_seen) begin
      errors++; $display("FAIL abort_rerun got count=%0d done=%0d exp count=4 last=%0d done=1", obs_data.size(), done_seen, exp_q[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    do_start(3, 5, 30);
    stream.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({stream.out_valid, stream.out_data, stream.out_idx, stream.out_ovf, stream.out_last, busy, done} !== '0) begin
      errors++; $display("FAIL mid_reset got valid=%b data=%h idx=%0d busy=%b done=%b exp all 0",
                         stream.out_valid, stream.out_data, stream.out_idx, busy, done);
    end
    stream.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || stream.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got done=%b valid=%b exp 0 0", done, stream.out_valid);
    end
    do_start(1, 1, 6);
    build_exp(1, 1, 6);
    collect(0, 20);
    checks++;
    if (obs_data.size() != 7) begin
      errors++; $display("FAIL post_reset_count got=%0d exp=7", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < 7; i++) begin
      checks++;
      if (obs_data[i] !== exp_q[i] || obs_idx[i] !== IW'(i)) begin
        errors++; $display("FAIL post_reset_term%0d got data=%0d idx=%0d exp data=%0d idx=%0d", i, obs_data[i], obs_idx[i], exp_q[i], i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int ln;
    for (int it = 0; it < 8; it++) begin
      a  = $urandom;
      b  = $urandom;
      ln = (it == 0) ? 1 : $urandom_range(0, 24);
      do_start(a, b, ln);
      build_exp(a, b, ln);
      collect(2, 200);
      checks++;
      if (obs_data.size() != exp_q.size() || !done_seen || hold_bad != 0 || busy_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_shape got count=%0d done=%0d unstable=%0d busy_bad=%0d exp count=%0d done=1 0 0",
                 it, obs_data.size(), done_seen, hold_bad, busy_bad, exp_q.size());
      end
      for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_data[i] !== exp_q[i] || obs_ovf[i] !== exp_ovf_q[i] ||
            obs_idx[i] !== IW'(i) || obs_last[i] !== (i == ln)) begin
          errors++;
          $display("FAIL rand%0d_term%0d got data=%h ovf=%b idx=%0d last=%b exp data=%h ovf=%b idx=%0d last=%b",
                   it, i, obs_data[i], obs_ovf[i], obs_idx[i], obs_last[i], exp_q[i], exp_ovf_q[i], i, (i == ln));
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_lucas_backpressure();
    test_overflow();
    test_last_zero();
    test_start_in_run();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
